// File: rtl/riscv_ifetch_queue.sv
// Instruction prefetch queue: issues sequential word requests to instruction memory,
// buffers in-order responses with their PCs, and flushes stale words on redirect.
module riscv_ifetch_queue #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req_valid,
    input  logic            i_imem_req_ready,
    output logic [XLEN-1:0] o_imem_req_addr,
    input  logic            i_imem_rsp_valid,
    input  logic [31:0]     i_imem_rsp_data,
    output logic            o_instr_valid,
    output logic [31:0]     o_instr,
    output logic [XLEN-1:0] o_instr_pc,
    input  logic            i_instr_ready,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
    logic [CW-1:0]   inflight_q, inflight_d;
    logic [CW-1:0]   discard_q, discard_d;
    logic [CW-1:0]   count_q, count_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;

    logic [XLEN-1:0] fifo_pc_q    [DEPTH];
    logic [31:0]     fifo_instr_q [DEPTH];

    logic [CW:0] credit_used;
    logic        req_fire;
    logic        rsp_fire;
    logic        push;
    logic        pop;

    // Stale in-flight words still hold credit, so a push can never find the FIFO full.
    assign credit_used      = {1'b0, inflight_q} + {1'b0, count_q};
    assign o_imem_req_valid = !i_rst && (credit_used < (CW + 1)'(DEPTH));
    assign o_imem_req_addr  = req_pc_q;

    assign req_fire = o_imem_req_valid & i_imem_req_ready;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_fire = i_imem_rsp_valid & (inflight_q != '0);
    assign push     = rsp_fire & (discard_q == '0) & !i_redirect;
    assign pop      = o_instr_valid & i_instr_ready & !i_redirect;

    assign o_instr_valid = (count_q != '0);
    assign o_instr       = fifo_instr_q[rd_ptr_q];
    assign o_instr_pc    = fifo_pc_q[rd_ptr_q];

    always_comb begin
        req_pc_d   = req_pc_q;
        rsp_pc_d   = rsp_pc_q;
        discard_d  = discard_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_fire);

        if (i_redirect) begin
            // Everything still in flight after this edge belongs to the old path.
            req_pc_d  = i_redirect_pc & ~XLEN'(3);
            rsp_pc_d  = i_redirect_pc & ~XLEN'(3);
            discard_d = inflight_d;
            count_d   = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
        end else begin
            if (req_fire) begin
                req_pc_d = req_pc_q + XLEN'(4);
            end
            if (rsp_fire && (discard_q != '0)) begin
                discard_d = discard_q - CW'(1);
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + XLEN'(4);
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            req_pc_q   <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            inflight_q <= '0;
            discard_q  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
        end else begin
            req_pc_q   <= req_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            fifo_pc_q[wr_ptr_q]    <= rsp_pc_q;
            fifo_instr_q[wr_ptr_q] <= i_imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_riscv_ifetch_queue.sv
// Bench for riscv_ifetch_queue: random memory/fetch/redirect stimulus, a generation-tagged
// reference of the instruction stream, and a scoreboard monitor comparing every cycle.
module tb_riscv_ifetch_queue;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        o_imem_req_valid;
    logic        i_imem_req_ready;
    logic [31:0] o_imem_req_addr;
    logic        i_imem_rsp_valid;
    logic [31:0] i_imem_rsp_data;
    logic        o_instr_valid;
    logic [31:0] o_instr;
    logic [31:0] o_instr_pc;
    logic        i_instr_ready;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;

    riscv_ifetch_queue #(
        .XLEN     (32),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .o_imem_req_valid (o_imem_req_valid),
        .i_imem_req_ready (i_imem_req_ready),
        .o_imem_req_addr  (o_imem_req_addr),
        .i_imem_rsp_valid (i_imem_rsp_valid),
        .i_imem_rsp_data  (i_imem_rsp_data),
        .o_instr_valid    (o_instr_valid),
        .o_instr          (o_instr),
        .o_instr_pc       (o_instr_pc),
        .i_instr_ready    (i_instr_ready),
        .i_redirect       (i_redirect),
        .i_redirect_pc    (i_redirect_pc)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [31:0] addr;
        int          gen;
        int          due;
    } req_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    req_t        pending[$];   // accepted requests not yet answered by the memory
    ent_t        exp_q[$];     // words fetch should see, in order
    logic [31:0] acc_log[$];   // addresses of accepted requests
    logic [31:0] next_req;
    int          gen, cyc, last_due, lat;
    int          p_ready, p_pop, p_redir;
    bit          rsp_on_bus, rst_prev;
    int          rsp_gen;
    logic [31:0] rsp_addr;
    int          total, bad;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h5A00_0013 ^ {a[15:0], a[31:16]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // One cycle of stimulus, applied at the falling edge.
    task automatic drive_cycle(input bit rst, input bit force_redir, input logic [31:0] tgt,
                               input bit spur, input bit force_pop);
        req_t r;
        @(negedge i_clk);
        i_rst            = rst;
        rsp_on_bus       = 1'b0;
        i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data  = $urandom;
        if (pending.size() > 0 && pending[0].due <= cyc) begin
            r                = pending.pop_front();
            rsp_on_bus       = 1'b1;
            rsp_gen          = r.gen;
            rsp_addr         = r.addr;
            i_imem_rsp_valid = 1'b1;
            i_imem_rsp_data  = mem_word(r.addr);
        end else if (spur) begin
            i_imem_rsp_valid = 1'b1;
        end
        i_imem_req_ready = ($urandom_range(99) < p_ready);
        i_instr_ready    = force_pop || ($urandom_range(99) < p_pop);
        i_redirect       = force_redir || ($urandom_range(999) < p_redir);
        if (force_redir) begin
            i_redirect_pc = tgt;
        end else if ($urandom_range(3) == 0) begin
            i_redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
        end else begin
            i_redirect_pc = $urandom;
        end
    endtask

    // Monitor / scoreboard: samples mid-cycle, compares, then advances the reference.
    initial begin
        ent_t e;
        req_t r;
        int   used;
        forever begin
            @(negedge i_clk);
            #3;
            if (i_rst) begin
                chk("req_valid_in_reset", 32'(o_imem_req_valid), 32'd0);
                if (rst_prev) chk("instr_valid_after_reset", 32'(o_instr_valid), 32'd0);
                pending.delete();
                exp_q.delete();
                next_req = RESET_PC;
                last_due = 0;
                gen++;
                rst_prev = 1'b1;
            end else begin
                used = pending.size() + int'(rsp_on_bus) + exp_q.size();
                chk("req_valid_credit", 32'(o_imem_req_valid), 32'(used < DEPTH));
                if (o_imem_req_valid) chk("req_addr", o_imem_req_addr, next_req);
                chk("instr_valid", 32'(o_instr_valid), 32'(exp_q.size() > 0));
                if (o_instr_valid && exp_q.size() > 0) begin
                    chk("head_pc", o_instr_pc, exp_q[0].pc);
                    chk("head_instr", o_instr, exp_q[0].instr);
                end
                if (o_instr_valid && i_instr_ready && !i_redirect && exp_q.size() > 0)
                    void'(exp_q.pop_front());
                if (rsp_on_bus && !i_redirect && rsp_gen == gen) begin
                    e.pc    = rsp_addr;
                    e.instr = mem_word(rsp_addr);
                    exp_q.push_back(e);
                end
                if (o_imem_req_valid && i_imem_req_ready) begin
                    r.addr   = next_req;
                    r.gen    = gen;
                    r.due    = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
                    last_due = r.due;
                    pending.push_back(r);
                    acc_log.push_back(o_imem_req_addr);
                    next_req = next_req + 32'd4;
                end
                if (i_redirect) begin
                    exp_q.delete();
                    gen++;
                    next_req = i_redirect_pc & ~32'd3;
                end
                rst_prev = 1'b0;
            end
            cyc++;
        end
    end

    initial begin
        bit hit;
        bit coin;
        total = 0; bad = 0; cyc = 0; gen = 0; last_due = 0; lat = 1;
        next_req = RESET_PC; rst_prev = 1'b0; rsp_on_bus = 1'b0;
        i_rst = 1'b1; i_imem_req_ready = 1'b0; i_imem_rsp_valid = 1'b0;
        i_imem_rsp_data = '0; i_instr_ready = 1'b0; i_redirect = 1'b0; i_redirect_pc = '0;
        p_ready = 100; p_pop = 100; p_redir = 0;

        // Stream after reset, single-cycle memory.
        repeat (3) drive_cycle(1, 0, 0, 0, 0);
        repeat (20) drive_cycle(0, 0, 0, 0, 0);

        // Fetch stalled: queue fills, then requests stop.
        repeat (2) drive_cycle(1, 0, 0, 0, 0);
        p_pop = 0; lat = 2;
        acc_log.delete();
        repeat (12) drive_cycle(0, 0, 0, 0, 0);
        #2;
        chk("stall_req_count", 32'(acc_log.size()), 32'd4);
        chk("stall_req_valid", 32'(o_imem_req_valid), 32'd0);
        chk("stall_head_valid", 32'(o_instr_valid), 32'd1);
        chk("stall_head_pc", o_instr_pc, 32'h0);
        p_pop = 100;
        drive_cycle(0, 0, 0, 0, 0);
        drive_cycle(0, 0, 0, 0, 0);
        #2;
        chk("resume_req_valid", 32'(o_imem_req_valid), 32'd1);
        chk("resume_req_addr", o_imem_req_addr, 32'h10);
        repeat (10) drive_cycle(0, 0, 0, 0, 0);

        // Redirect with three outstanding and one accepted in the same cycle.
        repeat (2) drive_cycle(1, 0, 0, 0, 0);
        lat = 4;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            if (pending.size() == 3 && pending[0].due > cyc && o_imem_req_valid) begin
                drive_cycle(0, 1, 32'h100, 0, 0);
                hit = 1'b1;
            end else begin
                drive_cycle(0, 0, 0, 0, 0);
            end
        end
        chk("redirect_setup_reached", 32'(hit), 32'd1);
        drive_cycle(0, 0, 0, 0, 0);
        #2;
        chk("redirect_req_valid", 32'(o_imem_req_valid), 32'd1);
        chk("redirect_req_addr", o_imem_req_addr, 32'h100);
        hit = 1'b0;
        for (int i = 0; i < 30 && !hit; i++) begin
            drive_cycle(0, 0, 0, 0, 0);
            #2;
            hit = o_instr_valid;
        end
        chk("redirect_first_out_seen", 32'(hit), 32'd1);
        chk("redirect_first_pc", o_instr_pc, 32'h100);

        // Random traffic with forced response+pop+redirect coincidences.
        p_ready = 70; p_pop = 70; p_redir = 30;
        for (int i = 0; i < 400; i++) begin
            if (i % 50 == 0) lat = $urandom_range(1, 4);
            coin = pending.size() > 0 && pending[0].due <= cyc && o_instr_valid
                   && ($urandom_range(3) == 0);
            drive_cycle(0, coin, $urandom, 0, coin);
            if (coin) begin
                drive_cycle(0, 0, 0, 0, 0);
                #2;
                chk("coincident_flush", 32'(o_instr_valid), 32'd0);
            end
        end

        // Backpressure and address wrap.
        p_redir = 0; p_ready = 50; p_pop = 100; lat = 1;
        drive_cycle(0, 1, 32'hFFFF_FFFE, 0, 0);
        #4;
        acc_log.delete();
        repeat (12) drive_cycle(0, 0, 0, 0, 0);
        #4;
        chk("wrap_req_count_ok", 32'(acc_log.size() >= 2), 32'd1);
        if (acc_log.size() >= 2) begin
            chk("wrap_first_addr", acc_log[0], 32'hFFFF_FFFC);
            chk("wrap_second_addr", acc_log[1], 32'h0000_0000);
        end

        // Reset mid-operation, then a late response that must be ignored.
        p_ready = 100; p_pop = 0; lat = 3;
        for (int i = 0; i < 20 && exp_q.size() < 2; i++) drive_cycle(0, 0, 0, 0, 0);
        chk("midreset_queue_filled", 32'(exp_q.size() >= 2), 32'd1);
        repeat (2) drive_cycle(1, 0, 0, 0, 0);
        p_pop = 100;
        drive_cycle(0, 0, 0, 1, 0);
        #2;
        chk("post_reset_req_valid", 32'(o_imem_req_valid), 32'd1);
        chk("post_reset_req_addr", o_imem_req_addr, RESET_PC);
        drive_cycle(0, 0, 0, 0, 0);
        #2;
        chk("late_rsp_ignored", 32'(o_instr_valid), 32'd0);

        p_ready = 80; p_pop = 80; p_redir = 20;
        for (int i = 0; i < 300; i++) begin
            if (i % 60 == 0) lat = $urandom_range(1, 3);
            drive_cycle(0, 0, 0, 0, 0);
        end
        @(negedge i_clk);
        #4;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
